processor_back_end: RTL
=======================

# processor_back_end

Execute, memory and writeback half of the 16-bit pipeline. It consumes the control and operand bundle produced by the ID/EXE pipe, runs the ALU, resolves jumps, performs data-memory accesses over a ready/request handshake, and returns the writeback bundle to the ID register file. It also returns the jump bundle to IF and a stall to the front end.

## Interface

**Parameters**
- `ARQ`, default 16: datapath width.
- `MEM_ADDR`, default 13: data/jump address width.

**Ports**
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `wb_enable_exe_in`, `rd_mem_exe_in`, `wr_mem_exe_in`, `mux_exe_exe_in`, `mux_mem_exe_in`, `jop_exe_in`, `jenable_exe_in`  in  1 each: control bits from the ID/EXE pipe.
- `src1_exe_in`, `src2_exe_in`, `src3_exe_in`, `imm_exe_in`  in  ARQ: operands. `src3` is store data.
- `alu_op_exe_in`  in  2: ALU operation.
- `jaddr_exe_in`  in  MEM_ADDR: jump target.
- `rd_exe_in`  in  4: destination register index.
- `mem_rdata`  in  ARQ: data-memory read data, valid when `mem_ready`=1.
- `mem_ready`  in  1: data-memory access complete.
- `mem_req`, `mem_we`  out  1: memory request and write select.
- `mem_addr`  out  MEM_ADDR: memory address.
- `mem_wdata`  out  ARQ: memory write data.
- `branch_taken`  out  1: registered one-cycle jump pulse to IF.
- `jump_address`  out  MEM_ADDR: jump target, valid with `branch_taken`.
- `stall_out`  out  1: freeze IF, IF/ID and ID/EXE.
- `wb_result_in`  out  ARQ: writeback data to ID.
- `wr_reg_en`  out  1: register-file write enable.
- `wb_reg_addr`  out  4: writeback register index.

## Operation

**EXE (combinational from the ID/EXE pipe)**
- Operand B = `imm_exe_in` when `mux_exe_exe_in`=1, otherwise `src2_exe_in`.
- ALU, result truncated to ARQ bits with no flags:
  - 00: add (wraps)
  - 01: src1 − B (wraps)
  - 10: AND
  - 11: XOR
- Jump when `jenable`=1:
  - `jop`=0: unconditional.
  - `jop`=1: taken only if the ALU result is 0.
- Squash: while `branch_taken`=1, the EXE input that cycle (delay slot) is a bubble. Its wb, rd, wr and jenable bits are forced to 0.

**EXE/MEM register**
- Holds alu_result, src3, rd, wb_en, rd_mem, wr_mem, mux_mem.
- Loads every cycle unless `stall_out`=1.

**MEM FSM**
- States: IDLE, WAIT.
- IDLE, stage holds `rd_mem` or `wr_mem`:
  - Assert `mem_req`=1, `mem_we`=`wr_mem`, `mem_addr`=alu_result[MEM_ADDR-1:0], `mem_wdata`=src3.
  - `mem_ready`=1 in the same cycle: complete, stay in IDLE.
  - Otherwise: go to WAIT.
- WAIT: hold `mem_req` and all address/data stable. On `mem_ready`=1, complete and go to IDLE.
- `stall_out` = `mem_req` & ~`mem_ready` (combinational).
- `rd_mem` and `wr_mem` both set: treat as write. No read data is captured.

**MEM/WB register**
- On a completed or non-memory op, captures:
  - `wb_result_in` = `mux_mem` ? `mem_rdata` : alu_result
  - `wr_reg_en` = wb_en
  - `wb_reg_addr` = rd
- While stalled, loads a bubble (`wr_reg_en`=0). `wb_result_in` and `wb_reg_addr` hold their previous values.

## Timing

- Reset (`rst`=0, asynchronous):
  - All pipeline registers are cleared and the FSM goes to IDLE.
  - Outputs `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `branch_taken`, `jump_address`, `stall_out`, `wb_result_in`, `wr_reg_en` and `wb_reg_addr` are all 0.
- Reset mid-access: the access is abandoned and `mem_req` drops immediately. No writeback results.
- ALU op presented in cycle N:
  - Edge N+1: enters EXE/MEM.
  - Edge N+2: appears on `wb_result_in`/`wr_reg_en`, a 2-cycle latency.
- Memory op with `mem_ready` arriving k cycles after the request (k=0 means same cycle):
  - Writeback at edge N+2+k.
  - `stall_out` is high for k cycles.
- Jump resolved in cycle N:
  - `branch_taken`=1 and `jump_address` valid for exactly cycle N+1.
  - The instruction in EXE during cycle N+1 is squashed.
- Jump in EXE while `stall_out`=1: resolution is deferred. `branch_taken` pulses the cycle after the stall releases and EXE/MEM loads. No double pulse.
- `wr_reg_en` is a single-cycle pulse per instruction. Back-to-back instructions produce consecutive pulses.

## Test plan

- **Reset:** hold `rst`=0 with random inputs → all outputs 0. Release → first writeback no earlier than edge 2.
- **ALU writeback:**
  - src1=0x7FFF, src2=0x0001, op=00, wb=1, rd=3 → 2 cycles later `wb_result_in`=0x8000, `wr_reg_en`=1, `wb_reg_addr`=3.
  - op=01 with src1=0, imm=1, `mux_exe`=1 → 0xFFFF.
- **Load with wait:**
  - rd_mem=1, mux_mem=1, src1=0x0010, imm=0x0004, `mux_exe`=1. `mem_ready` is held 0 for 3 cycles, then 1 with `mem_rdata`=0xBEEF.
  - Required: `mem_addr`=0x0014 stable for 4 cycles, `stall_out` high for 3 cycles, then `wb_result_in`=0xBEEF and `wr_reg_en`=1.
- **Store:** wr_mem=1, src3=0x1234, address 0x1FFF, `mem_ready`=1 immediately → `mem_we`=1, `mem_wdata`=0x1234, no stall, `wr_reg_en`=0.
- **Conditional jump:**
  - jenable=1, jop=1, src1=src2=5, op=01, jaddr=0x0ABC → next cycle `branch_taken`=1 and `jump_address`=0x0ABC for one cycle. The following instruction (wb=1) produces no `wr_reg_en`.
  - src1≠src2 → no pulse.
- **Reset mid-access:** assert `rst`=0 while in WAIT → `mem_req` and `stall_out` drop immediately. After release, no stale writeback.

Source files
------------

// File: rtl/processor_back_end.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | processor_back_end: EXE / MEM / WB half of the 16-bit pipeline.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module processor_back_end #(
  parameter int ARQ      = 16,
  parameter int MEM_ADDR = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_enable_exe_in,
  input  logic                rd_mem_exe_in,
  input  logic                wr_mem_exe_in,
  input  logic                mux_exe_exe_in,
  input  logic                mux_mem_exe_in,
  input  logic                jop_exe_in,
  input  logic                jenable_exe_in,
  input  logic [ARQ-1:0]      src1_exe_in,
  input  logic [ARQ-1:0]      src2_exe_in,
  input  logic [ARQ-1:0]      src3_exe_in,
  input  logic [ARQ-1:0]      imm_exe_in,
  input  logic [1:0]          alu_op_exe_in,
  input  logic [MEM_ADDR-1:0] jaddr_exe_in,
  input  logic [3:0]          rd_exe_in,
  input  logic [ARQ-1:0]      mem_rdata,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [MEM_ADDR-1:0] mem_addr,
  output logic [ARQ-1:0]      mem_wdata,
  output logic                branch_taken,
  output logic [MEM_ADDR-1:0] jump_address,
  output logic                stall_out,
  output logic [ARQ-1:0]      wb_result_in,
  output logic                wr_reg_en,
  output logic [3:0]          wb_reg_addr
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t state_q, state_d;

  logic [ARQ-1:0]      op_b, alu_res;
  logic                squash, wb_eff, rdm_eff, wrm_eff, jen_eff, jump_d;
  logic                mem_op, complete;

  logic [ARQ-1:0]      alu_q, src3_q;
  logic [3:0]          rd_q;
  logic                wb_q, rdm_q, wrm_q, mxm_q;
  logic                branch_q;
  logic [MEM_ADDR-1:0] jaddr_q;
  logic [ARQ-1:0]      wb_result_q;
  logic                wr_reg_en_q;
  logic [3:0]          wb_reg_addr_q;

  // ---------------- EXE ----------------
  assign op_b = mux_exe_exe_in ? imm_exe_in : src2_exe_in;

  always_comb begin
    alu_res = '0;
    case (alu_op_exe_in)
      2'b00:   alu_res = src1_exe_in + op_b;
      2'b01:   alu_res = src1_exe_in - op_b;
      2'b10:   alu_res = src1_exe_in & op_b;
      default: alu_res = src1_exe_in ^ op_b;
    endcase
  end

  // The instruction in EXE while the jump pulse is out is the delay slot.
  assign squash  = branch_q;
  assign wb_eff  = wb_enable_exe_in & ~squash;
  assign rdm_eff = rd_mem_exe_in    & ~squash;
  assign wrm_eff = wr_mem_exe_in    & ~squash;
  assign jen_eff = jenable_exe_in   & ~squash;

  // A stalled jump stays in EXE and resolves once EXE/MEM accepts it.
  assign jump_d = jen_eff & (~jop_exe_in | (alu_res == '0)) & ~stall_out;

  // ---------------- MEM FSM ----------------
  assign mem_op = rdm_q | wrm_q;

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          mem_req = 1'b1;
          if (!mem_ready) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_req = 1'b1;
        if (mem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_out = mem_req & ~mem_ready;
  assign complete  = ~stall_out;
  assign mem_we    = mem_req & wrm_q;
  assign mem_addr  = mem_req ? alu_q[MEM_ADDR-1:0] : '0;
  assign mem_wdata = mem_req ? src3_q : '0;

  // ---------------- Registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      alu_q         <= '0;
      src3_q        <= '0;
      rd_q          <= '0;
      wb_q          <= 1'b0;
      rdm_q         <= 1'b0;
      wrm_q         <= 1'b0;
      mxm_q         <= 1'b0;
      branch_q      <= 1'b0;
      jaddr_q       <= '0;
      wb_result_q   <= '0;
      wr_reg_en_q   <= 1'b0;
      wb_reg_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      branch_q <= jump_d;
      if (jump_d) jaddr_q <= jaddr_exe_in;
      if (!stall_out) begin
        alu_q  <= alu_res;
        src3_q <= src3_exe_in;
        rd_q   <= rd_exe_in;
        wb_q   <= wb_eff;
        rdm_q  <= rdm_eff;
        wrm_q  <= wrm_eff;
        mxm_q  <= mux_mem_exe_in;
      end
      wr_reg_en_q <= complete & wb_q;
      if (complete) begin
        // A combined read/write is a store, so no read data is taken.
        wb_result_q   <= (mxm_q & ~wrm_q) ? mem_rdata : alu_q;
        wb_reg_addr_q <= rd_q;
      end
    end
  end

  assign branch_taken = branch_q;
  assign jump_address = jaddr_q;
  assign wb_result_in = wb_result_q;
  assign wr_reg_en    = wr_reg_en_q;
  assign wb_reg_addr  = wb_reg_addr_q;

endmodule
`default_nettype wire
